// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-write codes, EX/MEM state encoding
// and default datapath widths for the 16-bit, 16-register core.
package pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;

  // Which destinations a stage result writes (also the forwarding enable).
  typedef enum logic [1:0] {
    RW_NONE    = 2'b00,
    RW_OP1     = 2'b01,
    RW_OP1_OP2 = 2'b10,
    RW_OP1_R15 = 2'b11
  } rwrite_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_VALID     = 2'b01,
    ST_LOAD_WAIT = 2'b10
  } state_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bundle: EX results and data-memory response in, forwarding
// source bundle plus stall/error out. master = surrounding pipeline, slave = stage.
interface ex_mem_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
);

  logic              flush;
  logic              ex_valid;
  logic [REG_W-1:0]  ex_op1;
  logic [REG_W-1:0]  ex_op2;
  logic [DATA_W-1:0] ex_op1data;
  logic [DATA_W-1:0] ex_op2data;
  logic [DATA_W-1:0] ex_r15data;
  logic [1:0]        ex_rWrite;
  logic              ex_memRead;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;

  logic [REG_W-1:0]  memop1;
  logic [REG_W-1:0]  memop2;
  logic [DATA_W-1:0] memop1data;
  logic [DATA_W-1:0] memop2data;
  logic [DATA_W-1:0] memr15data;
  logic [1:0]        rWrite;
  logic              stall;
  logic              load_err;

  modport master (
    output flush, ex_valid, ex_op1, ex_op2, ex_op1data, ex_op2data, ex_r15data,
           ex_rWrite, ex_memRead, mem_rdata, mem_rdy,
    input  memop1, memop2, memop1data, memop2data, memr15data, rWrite, stall,
           load_err
  );

  modport slave (
    input  flush, ex_valid, ex_op1, ex_op2, ex_op1data, ex_op2data, ex_r15data,
           ex_rWrite, ex_memRead, mem_rdata, mem_rdy,
    output memop1, memop2, memop1data, memop2data, memr15data, rWrite, stall,
           load_err
  );

endinterface

// File: rtl/load_wait_timer.sv
// Counts cycles spent waiting for load data. expire flags the last allowed
// wait cycle; the counter saturates there rather than wrapping.
module load_wait_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count;

  // Clear on reset or load start, count waiting cycles, hold at the last value.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Captures ALU results every cycle, parks loads in
// LOAD_WAIT until memory answers (stalling upstream, forwarding disabled),
// and raises a sticky load_err if memory never answers.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int MAX_WAIT = 8
) (
  input logic            clk,
  input logic            rst,
  ex_mem_stage_if.slave  bus
);

  state_e            state;
  rwrite_e           rw_q;
  logic [REG_W-1:0]  op1_q, op2_q;
  logic [DATA_W-1:0] op1data_q, op2data_q, r15data_q;
  logic              load_err_q;

  logic load_start;
  logic wait_count_en;
  logic wait_expire;

  // A new load is accepted only from IDLE/VALID and only if not squashed.
  assign load_start    = !bus.flush && (state != ST_LOAD_WAIT)
                         && bus.ex_valid && bus.ex_memRead;
  assign wait_count_en = !bus.flush && (state == ST_LOAD_WAIT) && !bus.mem_rdy;

  load_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (load_start),
    .enable (wait_count_en),
    .expire (wait_expire)
  );

  // Stage FSM and captured bundle: rst beats flush beats the state action.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rw_q       <= RW_NONE;
      op1_q      <= '0;
      op2_q      <= '0;
      op1data_q  <= '0;
      op2data_q  <= '0;
      r15data_q  <= '0;
      load_err_q <= 1'b0;
    end else if (bus.flush) begin
      state <= ST_IDLE;
      rw_q  <= RW_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_VALID: begin
          if (!bus.ex_valid) begin
            state <= ST_IDLE;
            rw_q  <= RW_NONE;
          end else if (bus.ex_memRead) begin
            // Destination known now; data arrives later, so no forwarding yet.
            op1_q <= bus.ex_op1;
            op2_q <= bus.ex_op2;
            rw_q  <= RW_NONE;
            state <= ST_LOAD_WAIT;
          end else begin
            op1_q     <= bus.ex_op1;
            op2_q     <= bus.ex_op2;
            op1data_q <= bus.ex_op1data;
            op2data_q <= bus.ex_op2data;
            r15data_q <= bus.ex_r15data;
            rw_q      <= rwrite_e'(bus.ex_rWrite);
            state     <= ST_VALID;
          end
        end
        ST_LOAD_WAIT: begin
          if (bus.mem_rdy) begin
            // A load only ever writes op1, whatever EX asked for.
            op1data_q <= bus.mem_rdata;
            rw_q      <= RW_OP1;
            state     <= ST_VALID;
          end else if (wait_expire) begin
            load_err_q <= 1'b1;
            rw_q       <= RW_NONE;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          rw_q  <= RW_NONE;
        end
      endcase
    end
  end

  // stall is a pure decode of the state register: no path from mem_rdy.
  assign bus.stall      = (state == ST_LOAD_WAIT);
  assign bus.rWrite     = rw_q;
  assign bus.memop1     = op1_q;
  assign bus.memop2     = op2_q;
  assign bus.memop1data = op1data_q;
  assign bus.memop2data = op2data_q;
  assign bus.memr15data = r15data_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios with literal expectations
// plus a randomized run checked against a transaction-level model.
module tb_ex_mem_stage;
  import pipe_pkg::*;

  localparam int DW = 16;
  localparam int RWD = 4;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_W(DW), .REG_W(RWD)) bus ();

  ex_mem_stage #(.DATA_W(DW), .REG_W(RWD), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;

  // Model: what the stage should be presenting, plus an outstanding-load flag
  // and the number of wait cycles already spent on it.
  logic [RWD-1:0] m_op1, m_op2;
  logic [DW-1:0]  m_d1, m_d2, m_r15;
  logic [1:0]     m_rw;
  logic           m_err;
  bit             m_pending;
  int             m_waited;

  task automatic model_update();
    if (rst) begin
      m_op1 = '0; m_op2 = '0; m_d1 = '0; m_d2 = '0; m_r15 = '0;
      m_rw = 2'b00; m_err = 1'b0; m_pending = 0; m_waited = 0;
    end else if (bus.flush) begin
      m_pending = 0;
      m_rw = 2'b00;
    end else if (m_pending) begin
      if (bus.mem_rdy) begin
        m_d1 = bus.mem_rdata;
        m_rw = 2'b01;
        m_pending = 0;
      end else begin
        m_waited++;
        if (m_waited == MW) begin
          m_err = 1'b1;
          m_rw = 2'b00;
          m_pending = 0;
        end
      end
    end else if (!bus.ex_valid) begin
      m_rw = 2'b00;
    end else if (bus.ex_memRead) begin
      m_op1 = bus.ex_op1;
      m_op2 = bus.ex_op2;
      m_rw = 2'b00;
      m_pending = 1;
      m_waited = 0;
    end else begin
      m_op1 = bus.ex_op1;
      m_op2 = bus.ex_op2;
      m_d1 = bus.ex_op1data;
      m_d2 = bus.ex_op2data;
      m_r15 = bus.ex_r15data;
      m_rw = bus.ex_rWrite;
    end
  endtask

  // Advance one clock: model consumes the pre-edge inputs, outputs sampled 1ns later.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    bus.flush = 1'b0; bus.ex_valid = 1'b0; bus.ex_memRead = 1'b0;
    bus.ex_op1 = '0; bus.ex_op2 = '0; bus.ex_op1data = '0; bus.ex_op2data = '0;
    bus.ex_r15data = '0; bus.ex_rWrite = 2'b00; bus.mem_rdata = '0; bus.mem_rdy = 1'b0;
  endtask

  task automatic send_alu(input logic [3:0] op1, input logic [3:0] op2, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] r15, input logic [1:0] rw);
    bus.ex_valid = 1'b1; bus.ex_memRead = 1'b0;
    bus.ex_op1 = op1; bus.ex_op2 = op2; bus.ex_op1data = d1; bus.ex_op2data = d2;
    bus.ex_r15data = r15; bus.ex_rWrite = rw;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_alu(4'd9, 4'd2, 16'h7777, 16'h6666, 16'h5555, 2'b11);
    tick();
    send_alu(4'd7, 4'd1, 16'h0, 16'h0, 16'h0, 2'b00);
    bus.ex_memRead = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (bus.stall !== 1'b1) begin
      bad++; $display("FAIL reset_pre_stall got=%b exp=1", bus.stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus.memop1, bus.memop2, bus.memop1data, bus.memop2data, bus.memr15data,
         bus.rWrite, bus.stall, bus.load_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs op1=%h op2=%h d1=%h d2=%h r15=%h rw=%b stall=%b err=%b exp all 0",
               bus.memop1, bus.memop2, bus.memop1data, bus.memop2data, bus.memr15data,
               bus.rWrite, bus.stall, bus.load_err);
    end
  endtask

  task automatic test_alu();
    idle_inputs();
    send_alu(4'd3, 4'd0, 16'h1234, 16'h0, 16'h0, 2'b01);
    tick();
    idle_inputs();
    total++;
    if (bus.memop1 !== 4'd3) begin bad++; $display("FAIL alu_op1 got=%0d exp=3", bus.memop1); end
    total++;
    if (bus.memop1data !== 16'h1234) begin bad++; $display("FAIL alu_data got=%h exp=1234", bus.memop1data); end
    total++;
    if (bus.rWrite !== 2'b01) begin bad++; $display("FAIL alu_rw got=%b exp=01", bus.rWrite); end
    total++;
    if (bus.stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", bus.stall); end
  endtask

  task automatic test_mul_bubble();
    idle_inputs();
    send_alu(4'd4, 4'd0, 16'h0010, 16'h0, 16'hBEEF, 2'b11);
    tick();
    idle_inputs();
    total++;
    if (bus.rWrite !== 2'b11) begin bad++; $display("FAIL mul_rw got=%b exp=11", bus.rWrite); end
    total++;
    if (bus.memr15data !== 16'hBEEF) begin bad++; $display("FAIL mul_r15 got=%h exp=beef", bus.memr15data); end
    tick();
    total++;
    if (bus.rWrite !== 2'b00) begin bad++; $display("FAIL bubble_rw got=%b exp=00", bus.rWrite); end
    total++;
    if ({bus.memop1data, bus.memr15data} !== {16'h0010, 16'hBEEF}) begin
      bad++; $display("FAIL bubble_hold got=%h/%h exp=0010/beef", bus.memop1data, bus.memr15data);
    end
  endtask

  task automatic test_load();
    idle_inputs();
    send_alu(4'd5, 4'd6, 16'h0, 16'h0, 16'h0, 2'b10);
    bus.ex_memRead = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      // EX keeps showing something while stalled; it must be ignored.
      send_alu(4'd15, 4'd15, 16'hDEAD, 16'hDEAD, 16'hDEAD, 2'b11);
      total++;
      if (bus.stall !== 1'b1 || bus.rWrite !== 2'b00) begin
        bad++; $display("FAIL load_wait_c%0d stall=%b rw=%b exp stall=1 rw=00", c, bus.stall, bus.rWrite);
      end
      if (c == 4) begin bus.mem_rdy = 1'b1; bus.mem_rdata = 16'hA5A5; end
      tick();
    end
    idle_inputs();
    total++;
    if ({bus.stall, bus.rWrite, bus.memop1, bus.memop1data} !== {1'b0, 2'b01, 4'd5, 16'hA5A5}) begin
      bad++;
      $display("FAIL load_done stall=%b rw=%b op1=%0d d1=%h exp stall=0 rw=01 op1=5 d1=a5a5",
               bus.stall, bus.rWrite, bus.memop1, bus.memop1data);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] d1_before;
    idle_inputs();
    send_alu(4'd8, 4'd0, 16'h0, 16'h0, 16'h0, 2'b01);
    bus.ex_memRead = 1'b1;
    tick();
    idle_inputs();
    for (int c = 1; c <= MW; c++) begin
      total++;
      if (bus.stall !== 1'b1) begin bad++; $display("FAIL timeout_wait_c%0d stall=%b exp=1", c, bus.stall); end
      tick();
    end
    total++;
    if ({bus.stall, bus.load_err, bus.rWrite} !== {1'b0, 1'b1, 2'b00}) begin
      bad++; $display("FAIL timeout_exit stall=%b err=%b rw=%b exp 0/1/00", bus.stall, bus.load_err, bus.rWrite);
    end
    d1_before = bus.memop1data;
    bus.mem_rdy = 1'b1; bus.mem_rdata = 16'hFFFF;
    tick();
    idle_inputs();
    tick();
    total++;
    if ({bus.rWrite, bus.memop1data, bus.load_err} !== {2'b00, d1_before, 1'b1}) begin
      bad++; $display("FAIL late_rdy rw=%b d1=%h err=%b exp 00/%h/1", bus.rWrite, bus.memop1data, bus.load_err, d1_before);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.load_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", bus.load_err); end
  endtask

  task automatic test_flush_rdy();
    idle_inputs();
    send_alu(4'd2, 4'd0, 16'h1111, 16'h0, 16'h0, 2'b01);
    tick();
    send_alu(4'd3, 4'd0, 16'h0, 16'h0, 16'h0, 2'b01);
    bus.ex_memRead = 1'b1;
    tick();
    idle_inputs();
    tick();
    bus.flush = 1'b1; bus.mem_rdy = 1'b1; bus.mem_rdata = 16'h5A5A;
    tick();
    bus.flush = 1'b0;
    total++;
    if ({bus.rWrite, bus.stall, bus.memop1data} !== {2'b00, 1'b0, 16'h1111}) begin
      bad++; $display("FAIL flush_rdy rw=%b stall=%b d1=%h exp 00/0/1111", bus.rWrite, bus.stall, bus.memop1data);
    end
    tick();
    idle_inputs();
    total++;
    if ({bus.rWrite, bus.memop1data} !== {2'b00, 16'h1111}) begin
      bad++; $display("FAIL flush_after_rdy rw=%b d1=%h exp 00/1111", bus.rWrite, bus.memop1data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.ex_valid = ($urandom_range(0, 3) != 0);
      bus.ex_memRead = ($urandom_range(0, 2) == 0);
      bus.ex_op1 = RWD'($urandom); bus.ex_op2 = RWD'($urandom);
      bus.ex_op1data = DW'($urandom); bus.ex_op2data = DW'($urandom);
      bus.ex_r15data = DW'($urandom); bus.ex_rWrite = 2'($urandom);
      bus.mem_rdy = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = DW'($urandom);
      tick();
      total++;
      if ({bus.memop1, bus.memop2, bus.memop1data, bus.memop2data, bus.memr15data,
           bus.rWrite, bus.stall, bus.load_err} !==
          {m_op1, m_op2, m_d1, m_d2, m_r15, m_rw, logic'(m_pending), m_err}) begin
        bad++;
        $display("FAIL random_n%0d got op1=%h op2=%h d1=%h d2=%h r15=%h rw=%b st=%b err=%b exp op1=%h op2=%h d1=%h d2=%h r15=%h rw=%b st=%b err=%b",
                 n, bus.memop1, bus.memop2, bus.memop1data, bus.memop2data, bus.memr15data,
                 bus.rWrite, bus.stall, bus.load_err, m_op1, m_op2, m_d1, m_d2, m_r15, m_rw,
                 m_pending, m_err);
      end
      total++;
      if (bus.stall === 1'b1 && bus.rWrite !== 2'b00) begin
        bad++; $display("FAIL random_rw_under_stall_n%0d rw=%b exp=00", n, bus.rWrite);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul_bubble();
    test_load();
    test_timeout();
    test_flush_rdy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
